// File: rtl/data_sync_tx.sv
// Source side of a 4-phase req/ack bus synchronizer: word held on unsync_bus, level request on bus_enable.
// Accept-to-tx_done is at least 4+2*NUM_STAGES cycles; in_ready stays low from accept until the handshake closes.

module data_sync_tx #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 bus_ack,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 tx_done
);

    generate
        if (NUM_STAGES < 2) begin : g_bad_stages
            $error("data_sync_tx: NUM_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [NUM_STAGES-1:0] ack_sync;
    logic                  ack_s;
    logic                  accept;
    logic                  bus_enable_nxt;
    logic                  tx_done_nxt;

    // Only the last synchronizer stage is allowed to feed logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[NUM_STAGES-2:0], bus_ack};
        end
    end

    assign ack_s    = ack_sync[NUM_STAGES-1];
    assign in_ready = (state == IDLE) && !ack_s;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt      = state;
        bus_enable_nxt = bus_enable;
        tx_done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                bus_enable_nxt = 1'b0;
                if (accept) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                // One cycle of settle time for the bus before the request rises.
                state_nxt      = REQ;
                bus_enable_nxt = 1'b1;
            end
            REQ: begin
                bus_enable_nxt = 1'b1;
                if (ack_s) begin
                    state_nxt      = REL;
                    bus_enable_nxt = 1'b0;
                end
            end
            REL: begin
                bus_enable_nxt = 1'b0;
                if (!ack_s) begin
                    state_nxt   = IDLE;
                    tx_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt      = IDLE;
                bus_enable_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bus_enable <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            bus_enable <= bus_enable_nxt;
            tx_done    <= tx_done_nxt;
        end
    end

    // The bus only ever loads on accept, so it is frozen for the whole handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            unsync_bus <= '0;
        end else if (accept) begin
            unsync_bus <= in_data;
        end
    end

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx: destination receiver model on its own clock, scenario tasks, scoreboarded words.
`timescale 1ns/1ps

module tb_data_sync_tx;

    localparam int BW = 8;
    localparam int NS = 2;

    logic          clk = 1'b0;
    logic          dst_clk = 1'b0;
    logic          rst = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          bus_ack;
    logic [BW-1:0] unsync_bus;
    logic          bus_enable;
    logic          tx_done;

    int            checks = 0;
    int            failures = 0;
    int            ack_mode = 0;   // 0: destination model, 1: forced level, 2: zero-latency echo
    logic          ack_force = 1'b0;
    logic [1:0]    dst_sync;
    logic          dst_prev;
    logic [BW-1:0] rx_q[$];
    int            tx_cnt = 0;

    always #5 clk = ~clk;
    always #3.5 dst_clk = ~dst_clk;

    assign bus_ack = (ack_mode == 0) ? dst_sync[1] : (ack_mode == 1) ? ack_force : bus_enable;

    // Destination: synchronizes the request, latches the bus on its rising edge, echoes it as ack.
    always @(posedge dst_clk or negedge rst) begin
        if (!rst) begin
            dst_sync <= 2'b00;
            dst_prev <= 1'b0;
        end else begin
            dst_sync <= {dst_sync[0], bus_enable};
            dst_prev <= dst_sync[1];
            if (dst_sync[1] && !dst_prev) rx_q.push_back(unsync_bus);
        end
    end

    always @(negedge clk) if (tx_done === 1'b1) tx_cnt++;

    data_sync_tx #(.BUS_WIDTH(BW), .NUM_STAGES(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bus_ack   (bus_ack),
        .unsync_bus(unsync_bus),
        .bus_enable(bus_enable),
        .tx_done   (tx_done)
    );

    task automatic wait_tx(input int lim, output int n);
        n = 0;
        while (tx_done !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_en(input int lim, output int n);
        n = 0;
        while (bus_enable !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        ack_mode = 0; rst = 1'b0; in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (bus_enable !== 1'b0) begin failures++; $display("FAIL rst_bus_enable got=%b exp=0", bus_enable); end
        checks++; if (unsync_bus !== 8'h00) begin failures++; $display("FAIL rst_unsync_bus got=%h exp=00", unsync_bus); end
        checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL rst_tx_done got=%b exp=0", tx_done); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        int rb, tb0, n, bad;
        ack_mode = 0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        rb = rx_q.size(); tb0 = tx_cnt;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_first got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00;
        checks++; if (unsync_bus !== 8'hA5) begin failures++; $display("FAIL single_bus got=%h exp=a5", unsync_bus); end
        checks++; if (bus_enable !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL single_setup got=en%b rdy%b exp=en0 rdy0", bus_enable, in_ready); end
        @(negedge clk);
        checks++; if (bus_enable !== 1'b1) begin failures++; $display("FAIL single_enable got=%b exp=1", bus_enable); end
        n = 0; bad = 0;
        while (tx_done !== 1'b1 && n < 200) begin
            if (in_ready !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 200) begin failures++; $display("FAIL single_timeout got=%0d exp=<200", n); end
        checks++; if (bad != 0) begin failures++; $display("FAIL single_ready_low got=%0d exp=0", bad); end
        repeat (5) @(negedge clk);
        checks++; if (tx_cnt - tb0 != 1) begin failures++; $display("FAIL single_tx_pulses got=%0d exp=1", tx_cnt - tb0); end
        checks++; if (rx_q.size() - rb != 1 || rx_q[rb] !== 8'hA5) begin failures++; $display("FAIL single_rx got=%0d words exp=1 word a5", rx_q.size() - rb); end
    endtask

    task automatic test_busy_drop();
        int rb, tb0, n, bad;
        ack_mode = 0; rb = rx_q.size(); tb0 = tx_cnt;
        in_valid = 1'b1; in_data = 8'h11;
        @(negedge clk);
        wait_en(100, n);
        checks++; if (n >= 100) begin failures++; $display("FAIL busy_en_timeout got=%0d exp=<100", n); end
        in_data = 8'h22;
        n = 0; bad = 0;
        while (tx_done !== 1'b1 && n < 200) begin
            if (unsync_bus !== 8'h11) bad++;
            @(negedge clk);
            n++;
        end
        checks++; if (bad != 0 || n >= 200) begin failures++; $display("FAIL busy_hold got=%0d changes exp=0 (n=%0d)", bad, n); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (unsync_bus !== 8'h22) begin failures++; $display("FAIL busy_second_accept got=%h exp=22", unsync_bus); end
        wait_tx(200, n);
        repeat (3) @(negedge clk);
        checks++; if (tx_cnt - tb0 != 2) begin failures++; $display("FAIL busy_tx_pulses got=%0d exp=2", tx_cnt - tb0); end
        checks++; if (rx_q.size() - rb != 2 || rx_q[rb] !== 8'h11 || rx_q[rb+1] !== 8'h22) begin failures++; $display("FAIL busy_rx got=%0d words exp=11,22", rx_q.size() - rb); end
    endtask

    task automatic test_stale_ack();
        logic [BW-1:0] prev;
        int n, bad;
        ack_mode = 1; ack_force = 1'b1;
        repeat (4) @(negedge clk);
        prev = unsync_bus; in_valid = 1'b1; in_data = 8'h3C; bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b0 || unsync_bus !== prev || bus_enable !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stale_blocked got=%0d bad cycles exp=0", bad); end
        ack_force = 1'b0;
        for (int k = 1; k <= NS; k++) begin
            @(negedge clk);
            checks++; if (in_ready !== (k == NS)) begin failures++; $display("FAIL stale_ready_k%0d got=%b exp=%b", k, in_ready, (k == NS)); end
        end
        @(negedge clk);
        in_valid = 1'b0; ack_mode = 2;
        checks++; if (unsync_bus !== 8'h3C) begin failures++; $display("FAIL stale_accept got=%h exp=3c", unsync_bus); end
        wait_tx(200, n);
        checks++; if (n >= 200) begin failures++; $display("FAIL stale_tx_timeout got=%0d exp=<200", n); end
        @(negedge clk);
    endtask

    task automatic test_min_latency();
        logic [BW-1:0] d0, d1;
        int k;
        ack_mode = 2; d0 = BW'($urandom); d1 = BW'($urandom);
        in_valid = 1'b1; in_data = d0;
        @(negedge clk);
        in_data = d1; k = 0;
        while (tx_done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        checks++; if (k + 1 != 4 + 2 * NS) begin failures++; $display("FAIL minlat_first got=%0d cycles exp=%0d", k + 1, 4 + 2 * NS); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL minlat_ready_in_done got=%b exp=1", in_ready); end
        @(negedge clk);
        k++;
        in_valid = 1'b0;
        checks++; if (unsync_bus !== d1) begin failures++; $display("FAIL minlat_b2b_bus got=%h exp=%h", unsync_bus, d1); end
        while (tx_done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        checks++; if (k != 2 * (2 * NS + 4) - 1) begin failures++; $display("FAIL minlat_second got=%0d edges exp=%0d", k, 2 * (2 * NS + 4) - 1); end
        @(negedge clk);
    endtask

    task automatic test_slow_dst();
        logic [BW-1:0] d;
        int n, cnt, bad;
        ack_mode = 1; ack_force = 1'b0; d = BW'($urandom);
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        wait_en(100, n);
        cnt = 0; bad = 0; n = 0;
        while (bus_enable === 1'b1 && n < 200) begin
            cnt++;
            if (unsync_bus !== d) bad++;
            if (cnt == 20) ack_force = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++; if (cnt != 20 + NS) begin failures++; $display("FAIL slow_enable_len got=%0d exp=%0d", cnt, 20 + NS); end
        checks++; if (bad != 0 || unsync_bus !== d) begin failures++; $display("FAIL slow_bus_stable got=%h exp=%h", unsync_bus, d); end
        ack_force = 1'b0;
        wait_tx(100, n);
        checks++; if (n >= 100) begin failures++; $display("FAIL slow_tx_timeout got=%0d exp=<100", n); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        ack_mode = 0; in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        wait_en(100, n);
        checks++; if (bus_enable !== 1'b1) begin failures++; $display("FAIL rmid_reach_req got=%b exp=1", bus_enable); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus_enable !== 1'b0) begin failures++; $display("FAIL rmid_enable_async got=%b exp=0", bus_enable); end
        checks++; if (unsync_bus !== 8'h00) begin failures++; $display("FAIL rmid_bus_async got=%h exp=00", unsync_bus); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || bus_enable !== 1'b0) begin failures++; $display("FAIL rmid_resume got=rdy%b en%b exp=rdy1 en0", in_ready, bus_enable); end
    endtask

    task automatic test_back_to_back();
        int rb, tb0, idx, n, bad;
        logic acc;
        ack_mode = 0; rb = rx_q.size(); tb0 = tx_cnt;
        idx = 0; n = 0; in_data = 8'h00; in_valid = 1'b1;
        while (idx < 8 && n < 3000) begin
            acc = in_ready;
            @(negedge clk);
            n++;
            if (acc) begin idx++; in_data = BW'(idx); end
        end
        in_valid = 1'b0;
        n = 0;
        while (tx_cnt - tb0 < 8 && n < 500) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        checks++; if (tx_cnt - tb0 != 8) begin failures++; $display("FAIL b2b_tx_pulses got=%0d exp=8", tx_cnt - tb0); end
        checks++; if (rx_q.size() - rb != 8) begin failures++; $display("FAIL b2b_rx_count got=%0d exp=8", rx_q.size() - rb); end
        bad = 0;
        for (int i = 0; i < 8 && rb + i < rx_q.size(); i++) if (rx_q[rb+i] !== BW'(i)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_rx_order got=%0d wrong words exp=0", bad); end
    endtask

    task automatic test_random();
        logic [BW-1:0] exp_q[$];
        logic [BW-1:0] d, last;
        int rb, tb0, n, bad, to;
        logic acc;
        ack_mode = 0; rb = rx_q.size(); tb0 = tx_cnt; bad = 0; to = 0; last = unsync_bus;
        for (int w = 0; w < 12; w++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                if (bus_enable === 1'b1 && unsync_bus !== last) bad++;
                @(negedge clk);
            end
            d = BW'($urandom); in_valid = 1'b1; acc = 1'b0; n = 0;
            while (!acc && n < 500) begin
                if (in_ready === 1'b1) begin in_data = d; acc = 1'b1; end
                else in_data = BW'($urandom);
                if (bus_enable === 1'b1 && unsync_bus !== last) bad++;
                @(negedge clk);
                n++;
            end
            if (acc) begin exp_q.push_back(d); last = d; end else to++;
        end
        in_valid = 1'b0; n = 0;
        while (tx_cnt - tb0 < exp_q.size() && n < 1000) begin
            if (bus_enable === 1'b1 && unsync_bus !== last) bad++;
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checks++; if (bad != 0 || to != 0) begin failures++; $display("FAIL rand_bus_stable got=%0d changes %0d stalls exp=0", bad, to); end
        checks++; if (rx_q.size() - rb != exp_q.size()) begin failures++; $display("FAIL rand_rx_count got=%0d exp=%0d", rx_q.size() - rb, exp_q.size()); end
        bad = 0;
        for (int i = 0; i < exp_q.size() && rb + i < rx_q.size(); i++) if (rx_q[rb+i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL rand_rx_data got=%0d wrong words exp=0", bad); end
        checks++; if (tx_cnt - tb0 != exp_q.size()) begin failures++; $display("FAIL rand_tx_pulses got=%0d exp=%0d", tx_cnt - tb0, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_busy_drop();
        test_stale_ack();
        test_min_latency();
        test_slow_dst();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
